// File: rtl/bus1to2_pkg.sv
// bus1to2_pkg: shared bus widths, FSM encoding, request bundle and decode helper (rev 1.0)
`default_nettype none

package bus1to2_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } bus_req_t;

  function automatic logic addr_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

  // Watchdog width: enough bits to hold TIMEOUT, never narrower than one bit.
  function automatic int cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_watchdog.sv
// bus_watchdog: loadable saturating cycle counter with clear/enable and expiry flag (rev 1.0)
`default_nettype none

module bus_watchdog
  import bus1to2_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  localparam int W = cnt_width(TIMEOUT)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         enable,
  output logic         expired
);

  // With TIMEOUT=0 the counter simply parks at all-ones and never expires.
  localparam logic [W-1:0] LIMIT   = (TIMEOUT == 0) ? {W{1'b1}} : W'(TIMEOUT);
  localparam bit           ENABLED = (TIMEOUT != 0);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = ENABLED && (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bus1to2.sv
// bus1to2: registered 1-to-2 address-decoding demux with unmapped/timeout error completion (rev 1.0)
`default_nettype none

module bus1to2
  import bus1to2_pkg::*;
#(
  parameter logic [ADDR_W-1:0] S1_BASE  = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] S1_MASK  = 32'hF000_0000,
  parameter logic [ADDR_W-1:0] S2_BASE  = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] S2_MASK  = 32'hF000_0000,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [STRB_W-1:0] m_wstrb,
  output logic              m_ready,
  output logic [DATA_W-1:0] m_rdata,
  output logic              s1_valid,
  output logic [ADDR_W-1:0] s1_addr,
  output logic [DATA_W-1:0] s1_wdata,
  output logic [STRB_W-1:0] s1_wstrb,
  input  logic              s1_ready,
  input  logic [DATA_W-1:0] s1_rdata,
  output logic              s2_valid,
  output logic [ADDR_W-1:0] s2_addr,
  output logic [DATA_W-1:0] s2_wdata,
  output logic [STRB_W-1:0] s2_wstrb,
  input  logic              s2_ready,
  input  logic [DATA_W-1:0] s2_rdata,
  output logic              bus_err
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  logic [1:0]        state;
  bus_req_t          req_q;
  logic              sel_s2;
  logic              hit1;
  logic              hit2;
  logic              start_req;
  logic              in_req;
  logic              sel_ready;
  logic [DATA_W-1:0] sel_rdata;
  logic              expired;

  assign hit1      = addr_hit(m_addr, S1_BASE, S1_MASK);
  assign hit2      = addr_hit(m_addr, S2_BASE, S2_MASK);
  assign start_req = (state == ST_IDLE) && m_valid && (hit1 || hit2);
  assign in_req    = (state == ST_REQ);
  assign sel_ready = sel_s2 ? s2_ready : s1_ready;
  assign sel_rdata = sel_s2 ? s2_rdata : s1_rdata;

  // The counter reads 1 in the first REQ cycle, so it equals the number of REQ cycles spent.
  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (!in_req && !start_req),
    .load     (start_req),
    .load_val (CNT_W'(1)),
    .enable   (in_req),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      sel_s2  <= 1'b0;
      m_ready <= 1'b0;
      m_rdata <= '0;
      bus_err <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      m_rdata <= '0;
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m_valid) begin
            req_q.addr  <= m_addr;
            req_q.wdata <= m_wdata;
            req_q.wstrb <= m_wstrb;
            if (hit1 || hit2) begin
              sel_s2 <= !hit1;
              state  <= ST_REQ;
            end else begin
              m_ready <= 1'b1;
              m_rdata <= ERR_DATA;
              bus_err <= 1'b1;
              state   <= ST_RESP;
            end
          end
        end
        ST_REQ: begin
          // A ready landing on the expiry cycle still completes normally.
          if (sel_ready) begin
            m_ready <= 1'b1;
            m_rdata <= (req_q.wstrb == '0) ? sel_rdata : '0;
            state   <= ST_RESP;
          end else if (expired) begin
            m_ready <= 1'b1;
            m_rdata <= ERR_DATA;
            bus_err <= 1'b1;
            state   <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s1_valid = in_req && !sel_s2;
  assign s1_addr  = s1_valid ? req_q.addr  : '0;
  assign s1_wdata = s1_valid ? req_q.wdata : '0;
  assign s1_wstrb = s1_valid ? req_q.wstrb : '0;

  assign s2_valid = in_req && sel_s2;
  assign s2_addr  = s2_valid ? req_q.addr  : '0;
  assign s2_wdata = s2_valid ? req_q.wdata : '0;
  assign s2_wstrb = s2_valid ? req_q.wstrb : '0;

endmodule

`default_nettype wire

// File: tb/tb_bus1to2.sv
// tb_bus1to2: directed scenario bench for bus1to2 (TIMEOUT=4).
`default_nettype none

module tb_bus1to2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;
  logic        s1_valid, s1_ready, s2_valid, s2_ready;
  logic [31:0] s1_addr, s1_wdata, s1_rdata, s2_addr, s2_wdata, s2_rdata;
  logic [3:0]  s1_wstrb, s2_wstrb;
  logic        bus_err;

  always #5 clk = ~clk;

  bus1to2 #(.TIMEOUT(4)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .s1_valid(s1_valid), .s1_addr(s1_addr), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_ready(s1_ready), .s1_rdata(s1_rdata),
    .s2_valid(s2_valid), .s2_addr(s2_addr), .s2_wdata(s2_wdata), .s2_wstrb(s2_wstrb),
    .s2_ready(s2_ready), .s2_rdata(s2_rdata),
    .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  int          rdy_cyc, v1_cnt, v1_first, v1_last, v2_cnt;
  logic [31:0] got_rdata, seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;
  logic        got_err, next_ready, stray;

  // Issues one request at cycle 0 and plays both slaves; records what the DUT did.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int r1_cyc, input logic [31:0] r1_data,
                         input int r2_cyc, input logic [31:0] r2_data);
    rdy_cyc = -1; v1_cnt = 0; v1_first = -1; v1_last = -1; v2_cnt = 0;
    got_rdata = '0; got_err = 1'b0; stray = 1'b0; next_ready = 1'b0;
    seen_addr = '0; seen_wdata = '0; seen_wstrb = '0;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (s1_valid) begin
        v1_cnt++;
        if (v1_first < 0) begin
          v1_first = c; seen_addr = s1_addr; seen_wdata = s1_wdata; seen_wstrb = s1_wstrb;
        end
        v1_last = c;
      end else if (s1_addr != 0 || s1_wdata != 0 || s1_wstrb != 0) stray = 1'b1;
      if (s2_valid) begin
        if (v2_cnt == 0) begin
          seen_addr = s2_addr; seen_wdata = s2_wdata; seen_wstrb = s2_wstrb;
        end
        v2_cnt++;
      end else if (s2_addr != 0 || s2_wdata != 0 || s2_wstrb != 0) stray = 1'b1;
      if (m_ready) begin
        rdy_cyc = c; got_rdata = m_rdata; got_err = bus_err;
        break;
      end else if (bus_err || m_rdata != 0) stray = 1'b1;
      s1_ready = (c == r1_cyc); s1_rdata = (c == r1_cyc) ? r1_data : 32'h0;
      s2_ready = (c == r2_cyc); s2_rdata = (c == r2_cyc) ? r2_data : 32'h0;
    end
    m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s1_ready = 1'b0; s1_rdata = '0; s2_ready = 1'b0; s2_rdata = '0;
    @(posedge clk); #1;
    next_ready = m_ready;
  endtask

  task automatic test_reset;
    checks++;
    if ({m_ready, bus_err, s1_valid, s2_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {m_ready, bus_err, s1_valid, s2_valid});
    end
    checks++;
    if (m_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h want 00000000", m_rdata);
    end
    checks++;
    if ({s1_addr, s1_wdata, s1_wstrb, s2_addr, s2_wdata, s2_wstrb} !== '0) begin
      errors++; $display("FAIL reset_slave_fields got nonzero want 0");
    end
  endtask

  task automatic test_read_s1;
    run_txn(32'h0000_0010, 32'h0, 4'h0, 3, 32'h1234_5678, -1, 32'h0);
    checks++;
    if (rdy_cyc !== 4) begin errors++; $display("FAIL rd_s1_ready_cycle got %0d want 4", rdy_cyc); end
    checks++;
    if (v1_first !== 1 || v1_last !== 3 || v1_cnt !== 3 || v2_cnt !== 0) begin
      errors++; $display("FAIL rd_s1_valid_window got %0d..%0d n=%0d s2=%0d want 1..3 n=3 s2=0",
                         v1_first, v1_last, v1_cnt, v2_cnt);
    end
    checks++;
    if (seen_addr !== 32'h0000_0010) begin errors++; $display("FAIL rd_s1_addr got %h want 00000010", seen_addr); end
    checks++;
    if (got_rdata !== 32'h1234_5678 || got_err !== 1'b0) begin
      errors++; $display("FAIL rd_s1_resp got %h err=%b want 12345678 err=0", got_rdata, got_err);
    end
    checks++;
    if (next_ready !== 1'b0 || stray !== 1'b0) begin
      errors++; $display("FAIL rd_s1_quiet got next_ready=%b stray=%b want 0 0", next_ready, stray);
    end
  endtask

  task automatic test_write_s2;
    run_txn(32'h1000_0004, 32'hA5A5_A5A5, 4'hF, -1, 32'h0, 1, 32'hFFFF_FFFF);
    checks++;
    if (seen_addr !== 32'h1000_0004 || seen_wdata !== 32'hA5A5_A5A5 || seen_wstrb !== 4'hF) begin
      errors++; $display("FAIL wr_s2_fields got %h %h %h want 10000004 a5a5a5a5 f", seen_addr, seen_wdata, seen_wstrb);
    end
    checks++;
    if (rdy_cyc !== 2 || v1_cnt !== 0 || v2_cnt !== 1) begin
      errors++; $display("FAIL wr_s2_timing got ready=%0d s1=%0d s2=%0d want 2 0 1", rdy_cyc, v1_cnt, v2_cnt);
    end
    checks++;
    if (got_rdata !== 32'h0 || got_err !== 1'b0 || stray !== 1'b0) begin
      errors++; $display("FAIL wr_s2_resp got %h err=%b stray=%b want 00000000 0 0", got_rdata, got_err, stray);
    end
  endtask

  task automatic test_unmapped;
    run_txn(32'h2000_0000, 32'h0, 4'h0, 1, 32'h1111_1111, 1, 32'h2222_2222);
    checks++;
    if (rdy_cyc !== 1 || got_err !== 1'b1 || got_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL unmapped_resp got ready=%0d err=%b %h want 1 1 deadbeef", rdy_cyc, got_err, got_rdata);
    end
    checks++;
    if (v1_cnt !== 0 || v2_cnt !== 0 || next_ready !== 1'b0) begin
      errors++; $display("FAIL unmapped_quiet got s1=%0d s2=%0d next=%b want 0 0 0", v1_cnt, v2_cnt, next_ready);
    end
  endtask

  task automatic test_timeout;
    run_txn(32'h0000_0200, 32'h0, 4'h0, -1, 32'h0, -1, 32'h0);
    checks++;
    if (v1_first !== 1 || v1_last !== 4 || v1_cnt !== 4) begin
      errors++; $display("FAIL timeout_valid_window got %0d..%0d n=%0d want 1..4 n=4", v1_first, v1_last, v1_cnt);
    end
    checks++;
    if (rdy_cyc !== 5 || got_err !== 1'b1 || got_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL timeout_resp got ready=%0d err=%b %h want 5 1 deadbeef", rdy_cyc, got_err, got_rdata);
    end
    run_txn(32'h1000_0000, 32'h0000_0077, 4'h3, -1, 32'h0, -1, 32'h0);
    checks++;
    if (rdy_cyc !== 5 || got_err !== 1'b1 || got_rdata !== 32'hDEAD_BEEF || v2_cnt !== 4) begin
      errors++; $display("FAIL timeout_write got ready=%0d err=%b %h s2=%0d want 5 1 deadbeef 4",
                         rdy_cyc, got_err, got_rdata, v2_cnt);
    end
  endtask

  task automatic test_ready_at_timeout;
    run_txn(32'h0000_0300, 32'h0, 4'h0, 4, 32'hCAFE_F00D, -1, 32'h0);
    checks++;
    if (rdy_cyc !== 5 || got_err !== 1'b0 || got_rdata !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL ready_at_timeout got ready=%0d err=%b %h want 5 0 cafef00d", rdy_cyc, got_err, got_rdata);
    end
  endtask

  task automatic test_wrong_ready;
    run_txn(32'h0000_0100, 32'h0, 4'h0, 2, 32'h2222_2222, 1, 32'h1111_1111);
    checks++;
    if (rdy_cyc !== 3 || got_rdata !== 32'h2222_2222 || got_err !== 1'b0) begin
      errors++; $display("FAIL wrong_ready got ready=%0d %h err=%b want 3 22222222 0", rdy_cyc, got_rdata, got_err);
    end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h3000_0000; m_wdata = '0; m_wstrb = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (m_ready !== 1'b1 || bus_err !== 1'b1) begin
      errors++; $display("FAIL b2b_first got ready=%b err=%b want 1 1", m_ready, bus_err);
    end
    m_addr = 32'h0000_0040;
    @(posedge clk); #1;
    checks++;
    if (m_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%b want 0", m_ready); end
    @(posedge clk); #1;
    checks++;
    if (s1_valid !== 1'b1 || s1_addr !== 32'h0000_0040) begin
      errors++; $display("FAIL b2b_second_req got valid=%b %h want 1 00000040", s1_valid, s1_addr);
    end
    s1_ready = 1'b1; s1_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1;
    s1_ready = 1'b0; s1_rdata = '0;
    checks++;
    if (m_ready !== 1'b1 || m_rdata !== 32'h0BAD_F00D || bus_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second_resp got %b %h %b want 1 0badf00d 0", m_ready, m_rdata, bus_err);
    end
    m_valid = 1'b0; m_addr = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_req;
    @(posedge clk); #1;
    m_valid = 1'b1; m_addr = 32'h0000_0020; m_wstrb = 4'h0;
    @(posedge clk); #1;
    checks++;
    if (s1_valid !== 1'b1) begin errors++; $display("FAIL rst_req_pre got s1_valid=%b want 1", s1_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (s1_valid !== 1'b0) begin errors++; $display("FAIL rst_req_async got s1_valid=%b want 0", s1_valid); end
    m_valid = 1'b0; m_addr = '0;
    @(posedge clk); #1;
    checks++;
    if (m_ready !== 1'b0 || s1_addr !== 32'h0) begin
      errors++; $display("FAIL rst_req_hold got ready=%b addr=%h want 0 00000000", m_ready, s1_addr);
    end
    @(negedge clk); resetn = 1'b1;
    run_txn(32'h0000_0020, 32'h0, 4'h0, 2, 32'h5555_AAAA, -1, 32'h0);
    checks++;
    if (rdy_cyc !== 3 || got_rdata !== 32'h5555_AAAA || got_err !== 1'b0) begin
      errors++; $display("FAIL rst_req_after got ready=%0d %h err=%b want 3 5555aaaa 0", rdy_cyc, got_rdata, got_err);
    end
  endtask

  initial begin
    resetn = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s1_ready = 1'b0; s1_rdata = '0; s2_ready = 1'b0; s2_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); resetn = 1'b1;
    test_read_s1;
    test_write_s2;
    test_unmapped;
    test_timeout;
    test_ready_at_timeout;
    test_wrong_ready;
    test_back_to_back;
    test_reset_in_req;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got running want finished");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/bus1to2.md
# bus1to2

Registered 1-to-2 address-decoding bus demultiplexer, sitting directly downstream of the 2-to-1 arbiter. It takes the single arbitrated valid/ready request stream and routes each transaction to one of two slaves by address match. It holds the request fields in registers toward the slaves and returns the response one cycle later. Unmapped addresses and unresponsive slaves complete with an error response, so a bus master is never hung.

## Interface
- `S1_BASE`, default 32'h0000_0000: slave 1 match value.
- `S1_MASK`, default 32'hF000_0000: slave 1 match mask. Hit when `(addr & S1_MASK) == S1_BASE`.
- `S2_BASE`, default 32'h1000_0000: slave 2 match value.
- `S2_MASK`, default 32'hF000_0000: slave 2 match mask.
- `TIMEOUT`, default 255: maximum number of cycles in REQ. A value of 0 disables the timeout.
- `ERR_DATA`, default 32'hDEAD_BEEF: rdata returned on an error response.
- `clk` in 1: the single clock; all logic on posedge.
- `resetn` in 1: asynchronous, active-low reset.
- `m_valid` in 1, `m_addr` in 32, `m_wdata` in 32, `m_wstrb` in 4: upstream request (from the arbiter).
- `m_ready` out 1, `m_rdata` out 32: upstream completion.
- `s1_valid` out 1, `s1_addr` out 32, `s1_wdata` out 32, `s1_wstrb` out 4, `s1_ready` in 1, `s1_rdata` in 32: slave 1 port.
- `s2_*`: same set as `s1_*`, for slave 2.
- `bus_err` out 1: one-cycle pulse coincident with `m_ready` on an error response.

## Operation
- Protocol:
  - A master holds valid and its request fields stable until it sees ready high.
  - Ready is a one-cycle completion.
  - rdata is meaningful only on a read (`wstrb == 0`) in the ready cycle.
- State machine: IDLE, REQ, RESP.
- IDLE:
  - On `m_valid`, register addr/wdata/wstrb and decode the target.
  - S1 has priority when both slaves match.
  - Hit on either slave: go to REQ.
  - No match: load `ERR_DATA`, set the error flag, go to RESP.
- REQ:
  - Drive the selected `sX_valid = 1` with the registered fields.
  - The other slave port is held at all zeros.
  - On the selected `sX_ready`: capture `sX_rdata` on a read (0 on a write), clear the error flag, go to RESP.
  - A `ready` from the non-selected slave is ignored.
- Timeout:
  - The counter resets on entry to REQ and increments each REQ cycle.
  - If `TIMEOUT != 0` and the counter reaches `TIMEOUT` without ready: drop `sX_valid`, load `ERR_DATA` (also on a write), set the error flag, go to RESP.
  - Ready arriving in the same cycle as the timeout wins; no error is flagged.
  - Counter width is `$clog2(TIMEOUT+1)`, minimum 1. It saturates and never wraps.
- RESP:
  - `m_ready = 1` for exactly one cycle, with `m_rdata` = the captured data.
  - `bus_err` = the error flag.
  - Then go to IDLE.
- `m_rdata` reads 0 whenever `m_ready` is low.
- Back-to-back requests: if `m_valid` is high in the IDLE cycle after RESP, it is a new transaction and is captured.
- `m_valid` dropping mid-REQ (protocol violation): the slave transaction still completes, and RESP is still issued.

## Timing
- Reset (async assert, sync-safe deassert):
  - State is IDLE.
  - All outputs are 0: `m_ready`, `m_rdata`, `bus_err`, both `sX_valid`, and every `sX_addr`/`wdata`/`wstrb`.
  - Counter is 0.
  - Reset during REQ drops `sX_valid` immediately, without waiting for a clock.
- Cycle numbering for a hit, with `m_valid` sampled in IDLE at cycle 0:
  - `sX_valid` is high from cycle 1.
  - If the slave asserts ready at cycle 1+k (k ≥ 0), `m_ready` is high at cycle 2+k.
  - Minimum request-to-ready latency is 2 cycles.
- Unmapped address: `m_ready` and `bus_err` at cycle 1.
- Timeout: `sX_valid` is high for cycles 1..TIMEOUT; `m_ready` and `bus_err` are high at cycle TIMEOUT+1.
- No combinational path from any slave input to any upstream output; all upstream outputs are registered.
- At most one transaction is in flight. `m_ready` is never high two cycles in a row.

## Structure
- Shared bus package:
  - State encoding (IDLE/REQ/RESP).
  - Bus field widths (ADDR=32, DATA=32, STRB=4).
  - Default `ERR_DATA` constant.
- One sub-module is natural: `bus_watchdog`, a loadable saturating cycle counter with clear, enable and `expired` output, parameterised by `TIMEOUT`.
- Decode and the FSM stay in `bus1to2`.

## Test plan
- Read to 0x0000_0010 (S1); S1 asserts ready at cycle 3 with rdata 0x1234_5678 → `s1_valid` high for cycles 1–3, `s2_valid` stays 0, `m_ready` at cycle 4 with `m_rdata` 0x1234_5678, `bus_err` 0.
- Write to 0x1000_0004, wdata 0xA5A5_A5A5, wstrb 4'hF; S2 asserts ready at once → `s2_wdata`/`s2_wstrb` match, `m_ready` at cycle 2, `m_rdata` 0.
- Read to 0x2000_0000 (unmapped) → neither `sX_valid` toggles; `m_ready` and `bus_err` at cycle 1 with `m_rdata` 0xDEAD_BEEF.
- TIMEOUT=4, S1 never ready → `s1_valid` high for cycles 1–4, `m_ready` and `bus_err` at cycle 5 with 0xDEAD_BEEF.
- TIMEOUT=4, S1 ready exactly at cycle 4 → normal data returned, `bus_err` 0.
- `resetn` pulled low while in REQ → `s1_valid` drops without a clock edge; after release, the next read completes normally.
